// File: rtl/ahfp_floor_divide_pow2.sv
// Binary32 divide by 2^SHIFT, then round to integer (truncate or floor per word).
// Latency: 2 register stages (decode/mask, round/pack); throughput 1 word per cycle.
// Backpressure: in_ready = !s1_valid || !s2_valid || out_ready; full pipe drains and refills in one cycle.
module ahfp_floor_divide_pow2 #(
    parameter int SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact
);

    logic        adv1, adv2;
    logic        s1_valid, s2_valid;
    logic [31:0] s1_word, s2_word;
    logic [23:0] s1_lsb;
    logic        s1_inc, s1_inexact, s2_inexact;

    logic        sign;
    logic [7:0]  exp_in;
    logic [22:0] man_in;
    logic [9:0]  e_adj;
    logic [7:0]  sh;
    logic [23:0] lsb;
    logic [23:0] clr;
    logic        lost;
    logic [31:0] s1_word_d;
    logic        s1_inc_d, s1_inexact_d;

    logic [23:0] m_sum;
    logic [31:0] s2_word_d;

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // Stage 1: classify, mask the fraction bits below the binary point, flag loss.
    always_comb begin
        sign         = in_data[31];
        exp_in       = in_data[30:23];
        man_in       = in_data[22:0];
        e_adj        = {2'b00, exp_in} - 10'(SHIFT);
        sh           = 8'd150 - e_adj[7:0];
        lsb          = 24'h1 << sh;
        clr          = lsb - 24'd1;
        lost         = 1'b0;
        s1_word_d    = {sign, 31'b0};
        s1_inc_d     = 1'b0;
        s1_inexact_d = 1'b0;
        if (exp_in == 8'hFF) begin
            s1_word_d = {sign, exp_in, (man_in != 23'd0) ? (man_in | 23'h400000) : man_in};
        end else if (exp_in == 8'h00) begin
            s1_word_d = {sign, 31'b0};
        end else if ($signed(e_adj) < 10'sd127) begin
            s1_inexact_d = 1'b1;
            if (sign && in_mode)
                s1_word_d = 32'hBF80_0000;
        end else if ($signed(e_adj) < 10'sd150) begin
            lost         = |({1'b0, man_in} & clr);
            s1_inexact_d = lost;
            s1_word_d    = {sign, e_adj[7:0], man_in & ~clr[22:0]};
            s1_inc_d     = sign & in_mode & lost;
        end else begin
            s1_word_d = {sign, e_adj[7:0], man_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_word    <= 32'd0;
            s1_lsb     <= 24'd0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
        end else if (adv1) begin
            s1_valid   <= in_valid;
            s1_word    <= s1_word_d;
            s1_lsb     <= lsb;
            s1_inc     <= s1_inc_d;
            s1_inexact <= s1_inexact_d;
        end
    end

    // Stage 2: floor increment. The masked mantissa is aligned to lsb, so the
    // 24-bit sum tops out at 2^23, which is exactly the carry into the exponent.
    always_comb begin
        m_sum     = {1'b0, s1_word[22:0]} + s1_lsb;
        s2_word_d = s1_word;
        if (s1_inc)
            s2_word_d = {s1_word[31], s1_word[30:23] + {7'd0, m_sum[23]}, m_sum[22:0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid   <= 1'b0;
            s2_word    <= 32'd0;
            s2_inexact <= 1'b0;
        end else if (adv2) begin
            s2_valid   <= s1_valid;
            s2_word    <= s2_word_d;
            s2_inexact <= s1_inexact;
        end
    end

    assign out_valid   = s2_valid;
    assign out_data    = s2_word;
    assign out_inexact = s2_inexact;

endmodule

// File: tb/tb_ahfp_floor_divide_pow2.sv
// Directed bench for ahfp_floor_divide_pow2: SHIFT=2 and SHIFT=5 instances share stimulus.
// Covers rounding modes, specials, carry into exponent, backpressure and mid-stream reset.
module tb_ahfp_floor_divide_pow2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_mode, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_inexact;
    logic [31:0] out_data;
    logic        in_ready5, out_valid5, out_inexact5;
    logic [31:0] out_data5;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ahfp_floor_divide_pow2 #(.SHIFT(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inexact(out_inexact)
    );

    ahfp_floor_divide_pow2 #(.SHIFT(5)) dut5 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5), .out_inexact(out_inexact5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One isolated transaction with out_ready high; checks latency, data and inexact.
    task automatic run_one(input string tag, input logic [31:0] d, input logic md,
                           input logic [31:0] exp_d, input logic exp_x, input bit use5);
        int n;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = md;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        in_mode  = 1'b0;
        n = 1;
        @(negedge clk);
        while (!(use5 ? out_valid5 : out_valid) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
        check({tag, "_dat"}, use5 ? out_data5 : out_data, exp_d);
        check({tag, "_inx"}, {31'd0, use5 ? out_inexact5 : out_inexact}, {31'd0, exp_x});
    endtask

    logic [31:0] bw [5] = '{32'h4130_0000, 32'h3F80_0000, 32'hC130_0000, 32'h4E80_0000, 32'h7F80_0000};
    logic        bm [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] br [5] = '{32'h4000_0000, 32'h0000_0000, 32'hC040_0000, 32'h4D80_0000, 32'h7F80_0000};

    initial begin
        int idx, ocnt, gaps, cyc;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_inexact", {31'd0, out_inexact}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        run_one("pos11_m0",  32'h4130_0000, 1'b0, 32'h4000_0000, 1'b1, 1'b0);
        run_one("pos11_m1",  32'h4130_0000, 1'b1, 32'h4000_0000, 1'b1, 1'b0);
        run_one("neg11_m0",  32'hC130_0000, 1'b0, 32'hC000_0000, 1'b1, 1'b0);
        run_one("neg11_m1",  32'hC130_0000, 1'b1, 32'hC040_0000, 1'b1, 1'b0);
        run_one("neg7_m1",   32'hC0E0_0000, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
        run_one("one_m0",    32'h3F80_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("mone_m1",   32'hBF80_0000, 1'b1, 32'hBF80_0000, 1'b1, 1'b0);
        run_one("mone_m0",   32'hBF80_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
        run_one("nzero",     32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        run_one("denorm_m1", 32'h8000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        run_one("inf",       32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b0, 1'b0);
        run_one("snan",      32'h7F80_0001, 1'b1, 32'h7FC0_0001, 1'b0, 1'b0);
        run_one("big",       32'h4E80_0000, 1'b1, 32'h4D80_0000, 1'b0, 1'b0);
        run_one("sh5_64",    32'h4280_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b1);

        // Backpressure: out_ready low for 4 cycles while words are offered.
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        repeat (4) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = bw[idx];
            in_mode  = bm[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (out_valid) check("bp_hold_dat", out_data, br[0]);
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);

        ocnt = 0;
        gaps = 0;
        cyc  = 0;
        while (ocnt < 5 && cyc < 30) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (idx < 5) begin
                in_valid = 1'b1;
                in_data  = bw[idx];
                in_mode  = bm[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                check($sformatf("bp_out%0d", ocnt), out_data, br[ocnt]);
                ocnt++;
            end else begin
                gaps++;
            end
            cyc++;
        end
        check("bp_out_count", 32'(ocnt), 32'd5);
        check("bp_gaps", 32'(gaps), 32'd0);
        check("bp_in_count", 32'(idx), 32'd5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);

        // Reset with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h4130_0000;
        in_mode   = 1'b0;
        @(posedge clk); #1;
        in_data = 32'h3F80_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mr_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("mr_full_out_valid", {31'd0, out_valid}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mr_valid_drop", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_out_data", out_data, 32'd0);
        check("mr_out_inexact", {31'd0, out_inexact}, 32'd0);
        run_one("mr_next", 32'hC0E0_0000, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
        @(negedge clk);
        check("mr_no_stale", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
